// File: rtl/prime_query_master.sv
// Initiator for the prime-finder core: sweeps Intake over [first, last] by step,
// sanity-checks each returned prime pair and keeps pass/error/timeout statistics.
//
// state | meaning
// IDLE  | waiting for start; statistics and last_* hold
// ISSUE | one-cycle give_valid strobe with Intake = cur
// WAIT  | waiting for out_valid, bounded by the TIMEOUT down-counter
// CHECK | judge the captured prime pair, bump counters
// NEXT  | advance cur by step or finish the sweep
// DONE  | one-cycle done pulse, back to IDLE
module prime_query_master #(
  parameter int W       = 14,
  parameter int TIMEOUT = 4095,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  first,
  input  logic [W-1:0]  last,
  input  logic [7:0]    step,
  output logic          give_valid,
  output logic [W-1:0]  Intake,
  input  logic [W-1:0]  UpPrime,
  input  logic [W-1:0]  LowPrime,
  input  logic          out_valid,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  query_count,
  output logic [CW-1:0] err_count,
  output logic          timeout_err,
  output logic [W-1:0]  last_up,
  output logic [W-1:0]  last_low
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [W-1:0]  MIN_FIRST = W'(3);
  localparam logic [W-1:0]  MAX_LAST  = W'(9972);
  localparam logic [W-1:0]  MAX_PRIME = W'(9973);
  localparam logic [W-1:0]  PRIME_TWO = W'(2);
  localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]  cur;
  logic [W-1:0]  last_q;
  logic [7:0]    step_q;
  logic [TW-1:0] wait_cnt;

  logic [W-1:0] first_clamp;
  logic [W-1:0] last_clamp;
  logic [7:0]   step_eff;
  logic [W:0]   nxt;
  logic         next_over;
  logic         wait_tc;
  logic         up_shape_ok;
  logic         low_shape_ok;
  logic         check_pass;

  assign first_clamp = (first < MIN_FIRST) ? MIN_FIRST : first;
  assign last_clamp  = (last > MAX_LAST) ? MAX_LAST : last;
  assign step_eff    = (step == 8'd0) ? 8'd1 : step;

  // Extra carry bit catches wrap-around of cur + step.
  assign nxt       = {1'b0, cur} + (W+1)'(step_q);
  assign next_over = nxt[W] || (nxt > {1'b0, last_q});

  assign wait_tc = (wait_cnt == '0);

  assign up_shape_ok  = last_up[0] || (last_up == PRIME_TWO);
  assign low_shape_ok = last_low[0] || (last_low == PRIME_TWO);
  assign check_pass   = (last_up > cur) && (last_low < cur) &&
                        (last_low >= PRIME_TWO) && (last_up <= MAX_PRIME) &&
                        up_shape_ok && low_shape_ok;

  assign Intake = cur;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    give_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (first_clamp > last_clamp) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        give_valid = 1'b1;
        busy       = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (out_valid) begin
          state_nxt = S_CHECK;
        end else if (wait_tc) begin
          state_nxt = S_DONE;
        end
      end
      S_CHECK: begin
        busy      = 1'b1;
        state_nxt = S_NEXT;
      end
      S_NEXT: begin
        busy      = 1'b1;
        state_nxt = next_over ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur         <= '0;
      last_q      <= '0;
      step_q      <= '0;
      wait_cnt    <= '0;
      query_count <= '0;
      err_count   <= '0;
      timeout_err <= 1'b0;
      last_up     <= '0;
      last_low    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur         <= first_clamp;
            last_q      <= last_clamp;
            step_q      <= step_eff;
            query_count <= '0;
            err_count   <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_ISSUE: begin
          wait_cnt <= WAIT_LOAD;
        end
        S_WAIT: begin
          if (out_valid) begin
            last_up  <= UpPrime;
            last_low <= LowPrime;
          end else if (wait_tc) begin
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - TW'(1);
          end
        end
        S_CHECK: begin
          query_count <= query_count + W'(1);
          if (!check_pass && (err_count != {CW{1'b1}})) begin
            err_count <= err_count + CW'(1);
          end
        end
        S_NEXT: begin
          if (!next_over) begin
            cur <= nxt[W-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prime_query_master.sv
// Directed bench for prime_query_master: a stub core answers queries from a
// prime-search model, and a per-cycle compare checks strobes and sweep results.
module tb_prime_query_master;

  localparam int W  = 14;
  localparam int CW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  first = '0;
  logic [W-1:0]  last = '0;
  logic [7:0]    step = '0;
  logic          give_valid;
  logic [W-1:0]  intake;
  logic [W-1:0]  up_prime = '0;
  logic [W-1:0]  low_prime = '0;
  logic          out_valid = 1'b0;
  logic          busy;
  logic          done;
  logic [W-1:0]  query_count;
  logic [CW-1:0] err_count;
  logic          timeout_err;
  logic [W-1:0]  last_up;
  logic [W-1:0]  last_low;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prime_query_master #(.W(W), .TIMEOUT(TO), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .first(first), .last(last), .step(step),
    .give_valid(give_valid), .Intake(intake),
    .UpPrime(up_prime), .LowPrime(low_prime), .out_valid(out_valid),
    .busy(busy), .done(done), .query_count(query_count), .err_count(err_count),
    .timeout_err(timeout_err), .last_up(last_up), .last_low(last_low)
  );

  // stub modes: 0 real core, 1 up=Intake, 2 up even, 3 silent, 4 low=1, 5 up=9975
  int stub_mode = 0;
  int stub_lat  = 1;
  int st_cnt    = 0;
  int st_x      = 0;
  bit spur_req  = 0;

  int exp_q[$];
  int seen_q[$];
  int exp_qc, exp_ec, exp_to, exp_gap;
  int m_up = 0, m_low = 0;
  int cyc = 0, last_gv = 0, done_cnt = 0;
  bit first_gv = 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 0;
    return 1;
  endfunction

  function automatic int prime_above(input int x);
    int p = x + 1;
    while (!is_prime(p)) p++;
    return p;
  endfunction

  function automatic int prime_below(input int x);
    int p = x - 1;
    while (p >= 2 && !is_prime(p)) p--;
    return p;
  endfunction

  task automatic stub_resp(input int mode, input int x, output int up, output int low);
    up  = prime_above(x);
    low = prime_below(x);
    case (mode)
      1: up = x;
      2: up = up + 1;
      4: low = 1;
      5: up = 9975;
      default: ;
    endcase
  endtask

  function automatic bit pair_ok(input int x, input int up, input int low);
    return (up > x) && (low < x) && (low >= 2) && (up <= 9973) &&
           (up % 2 == 1 || up == 2) && (low % 2 == 1 || low == 2);
  endfunction

  task automatic stub_step();
    int u, l;
    out_valid = 1'b0;
    if (spur_req) begin
      out_valid = 1'b1;
      up_prime  = W'(1234);
      low_prime = W'(4321);
      spur_req  = 0;
    end
    if (st_cnt > 0) begin
      st_cnt--;
      if (st_cnt == 0) begin
        stub_resp(stub_mode, st_x, u, l);
        up_prime  = W'(u);
        low_prime = W'(l);
        out_valid = 1'b1;
      end
    end
    if (give_valid && stub_mode != 3) begin
      st_cnt = stub_lat;
      st_x   = int'(intake);
    end
  endtask

  task automatic monitor_step();
    cyc++;
    if (give_valid) begin
      chk("busy_at_issue", busy, 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_give_valid", 1, 0);
      end else begin
        chk("intake", intake, exp_q.pop_front());
      end
      if (!first_gv) chk("issue_gap", cyc - last_gv, exp_gap);
      first_gv = 0;
      last_gv  = cyc;
      seen_q.push_back(int'(intake));
    end
    if (done) begin
      done_cnt++;
      chk("busy_at_done", busy, 0);
      chk("queries_left", exp_q.size(), 0);
      chk("query_count", query_count, exp_qc);
      chk("err_count", err_count, exp_ec);
      chk("timeout_err", timeout_err, exp_to);
      chk("last_up", last_up, m_up);
      chk("last_low", last_low, m_low);
      if (exp_to != 0) chk("wait_cycles", cyc - last_gv, TO + 1);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    stub_step();
    monitor_step();
  endtask

  task automatic run_sweep(input int f, input int l, input int s, input int mode,
                           input int lat, input bit poke);
    int fc, lc, sc, x, u, lo;
    bit poked = 0;
    fc = (f < 3) ? 3 : f;
    lc = (l > 9972) ? 9972 : l;
    sc = (s == 0) ? 1 : s;
    exp_q.delete();
    seen_q.delete();
    exp_qc = 0; exp_ec = 0; exp_to = 0;
    if (fc <= lc) begin
      x = fc;
      while (1) begin
        exp_q.push_back(x);
        if (mode == 3) begin
          exp_to = 1;
          break;
        end
        stub_resp(mode, x, u, lo);
        exp_qc++;
        if (!pair_ok(x, u, lo) && exp_ec < 255) exp_ec++;
        m_up = u; m_low = lo;
        x += sc;
        if (x > lc) break;
      end
    end
    stub_mode = mode; stub_lat = lat; exp_gap = lat + 3;
    first_gv = 1; done_cnt = 0;
    first = W'(f); last = W'(l); step = 8'(s);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int n = 0; n < 20000 && done_cnt == 0; n++) begin
      if (poke && !poked && seen_q.size() >= 1) begin
        start = 1'b1;
        first = W'(100);
        poked = 1;
      end else begin
        start = 1'b0;
      end
      cycle();
    end
    start = 1'b0;
    if (done_cnt == 0) chk("done_within_bound", 0, 1);
    repeat (3) cycle();
    chk("done_pulses", done_cnt, 1);
    chk("busy_idle", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_give_valid"}, give_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_intake"}, intake, 0);
    chk({tag, "_query_count"}, query_count, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_last_up"}, last_up, 0);
    chk({tag, "_last_low"}, last_low, 0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) cycle();
    check_all_zero("reset");
    reset = 1'b1;
    cycle();

    run_sweep(10, 10, 1, 0, 3, 0);
    chk("lit_up_10", last_up, 11);
    chk("lit_low_10", last_low, 7);
    chk("lit_qc_10", query_count, 1);
    chk("lit_ec_10", err_count, 0);

    run_sweep(9970, 9972, 1, 0, 1, 0);
    chk("lit_up_9972", last_up, 9973);
    chk("lit_low_9972", last_low, 9967);
    chk("lit_qc_9970", query_count, 3);

    run_sweep(9000, 9972, 255, 0, 5, 1);
    chk("lit_qc_step255", query_count, 4);
    chk("lit_n_step255", seen_q.size(), 4);
    if (seen_q.size() == 4) chk("lit_last_step255", seen_q[3], 9765);

    run_sweep(0, 5, 0, 0, 2, 0);
    chk("lit_n_clamp", seen_q.size(), 3);
    if (seen_q.size() == 3) chk("lit_first_clamp", seen_q[0], 3);
    chk("lit_ec_clamp", err_count, 0);

    run_sweep(9971, 12000, 1, 0, 2, 0);
    chk("lit_n_lastclamp", seen_q.size(), 2);

    run_sweep(10, 10, 1, 1, 2, 0);
    chk("lit_ec_up_eq", err_count, 1);
    run_sweep(10, 10, 1, 2, 2, 0);
    chk("lit_ec_up_even", err_count, 1);
    run_sweep(20, 26, 3, 4, 1, 0);
    chk("lit_ec_low1", err_count, 3);
    run_sweep(3, 3, 1, 5, 1, 0);
    chk("lit_ec_up_big", err_count, 1);

    run_sweep(50, 60, 1, 3, 1, 0);
    chk("lit_to_flag", timeout_err, 1);
    chk("lit_to_qc", query_count, 0);

    run_sweep(100, 50, 1, 0, 1, 0);
    chk("lit_empty_n", seen_q.size(), 0);
    chk("lit_empty_to_cleared", timeout_err, 0);

    spur_req = 1;
    repeat (3) cycle();
    chk("idle_out_valid_up", last_up, m_up);
    chk("idle_out_valid_low", last_low, m_low);

    exp_q.delete();
    seen_q.delete();
    exp_q.push_back(40);
    stub_mode = 3; first_gv = 1;
    first = W'(40); last = W'(50); step = 8'd1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (6) cycle();
    reset = 1'b0;
    repeat (2) cycle();
    check_all_zero("midwait_reset");
    chk("midwait_issues", seen_q.size(), 1);
    reset = 1'b1;
    m_up = 0; m_low = 0;
    cycle();

    run_sweep(10, 14, 2, 0, 4, 0);
    chk("lit_after_reset_n", seen_q.size(), 3);
    chk("lit_after_reset_up", last_up, 17);
    chk("lit_after_reset_low", last_low, 13);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
